// File: rtl/fmdll_seq_pkg.sv
// Shared encodings for the FMDLL lock-acquisition sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: STATE_W, FSM state encodings (ST_*), correction direction type, PD-to-direction helper.
package fmdll_seq_pkg;

   localparam int STATE_W = 3;

   // FSM state encodings, also visible on state_o
   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_START  = 3'd1;
   localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
   localparam logic [STATE_W-1:0] ST_TRACK  = 3'd3;
   localparam logic [STATE_W-1:0] ST_LOCKED = 3'd4;
   localparam logic [STATE_W-1:0] ST_FAULT  = 3'd5;
   localparam logic [STATE_W-1:0] ST_FAIL   = 3'd6;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_e;

   // Both or neither request is a hold, which carries no direction
   function automatic dir_e pd_dir(input logic up, input logic dn);
      if (up && !dn)      return DIR_UP;
      else if (dn && !up) return DIR_DN;
      else                return DIR_NONE;
   endfunction

endpackage

// File: rtl/fmdll_code_ctr.sv
// Saturating up/down counter holding the delay-line control code.
// Latency: 1 cycle from load/up/dn to code.
// Backpressure: none; requests against a saturated bound are dropped (caller flags them via at_max/at_min).
// Ports: clk_ext, rst_n, load, load_val, up, dn -> code, at_max, at_min.
module fmdll_code_ctr #(
   parameter int CODE_W  = 6,
   parameter int RST_VAL = 32
) (
   input  logic              clk_ext,
   input  logic              rst_n,
   input  logic              load,
   input  logic [CODE_W-1:0] load_val,
   input  logic              up,
   input  logic              dn,
   output logic [CODE_W-1:0] code,
   output logic              at_max,
   output logic              at_min
);

   assign at_max = (code == {CODE_W{1'b1}});
   assign at_min = (code == '0);

   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n)
         code <= CODE_W'(RST_VAL);
      else if (load)
         code <= load_val;
      else if (up && !dn && !at_max)
         code <= code + CODE_W'(1);
      else if (dn && !up && !at_min)
         code <= code - CODE_W'(1);
   end

endmodule

// File: rtl/fmdll_lock_seq.sv
// FMDLL lock-acquisition sequencer: steers the delay-line code from PD up/dn, sequences HLD/PD resets, declares lock/relock/fail.
// Latency: 1 cycle from pd_up/pd_dn to code; all outputs registered.
// Backpressure: none; PD requests are sampled every clk_ext cycle and ignored outside TRACK/LOCKED.
// Ports: clk_ext, rst_n, en, reset_pd, pd_up, pd_dn -> code, pd_en, hld_rst_n, locked, fail, state_o
//        (+ dbg_relock, count of LOCKED->TRACK drops, when FMDLL_LOCK_SEQ_DBG_EN is defined).
module fmdll_lock_seq
   import fmdll_seq_pkg::*;
#(
   parameter int CODE_W     = 6,
   parameter int CODE_INIT  = 32,
   parameter int SETTLE_CYC = 16,
   parameter int LOCK_CNT   = 32,
   parameter int LOSS_RUN   = 4,
   parameter int MAX_RETRY  = 3
) (
   input  logic               clk_ext,
   input  logic               rst_n,
   input  logic               en,
   input  logic               reset_pd,
   input  logic               pd_up,
   input  logic               pd_dn,
   output logic [CODE_W-1:0]  code,
   output logic               pd_en,
   output logic               hld_rst_n,
   output logic               locked,
   output logic               fail,
   output logic [STATE_W-1:0] state_o
`ifdef FMDLL_LOCK_SEQ_DBG_EN
   ,
   output logic [7:0]         dbg_relock
`endif
);

   localparam int SETTLE_W = $clog2(SETTLE_CYC);
   localparam int LOCK_W   = $clog2(LOCK_CNT);
   localparam int RUN_W    = $clog2(LOSS_RUN + 1);
   localparam int RETRY_W  = $clog2(MAX_RETRY + 1);

   logic [STATE_W-1:0]  state, state_nxt;
   logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
   logic [LOCK_W-1:0]   lock_cnt, lock_nxt;
   logic [RUN_W-1:0]    run_cnt, run_nxt, run_inc;
   logic [RETRY_W-1:0]  retry, retry_nxt;
   dir_e                prev_dir, prev_nxt, cur_dir;
   logic                track_act, same_dir, at_max, at_min, sat_fault, hld_fault, code_load;

   assign track_act = (state == ST_TRACK) || (state == ST_LOCKED);
   assign cur_dir   = pd_dir(pd_up, pd_dn);
   assign same_dir  = (cur_dir != DIR_NONE) && (cur_dir == prev_dir);
   assign run_inc   = same_dir ? run_cnt + RUN_W'(1)
                               : ((cur_dir != DIR_NONE) ? RUN_W'(1) : '0);
   // A correction that would push past a bound means the loop cannot reach lock from here
   assign sat_fault = track_act && (((cur_dir == DIR_UP) && at_max) ||
                                    ((cur_dir == DIR_DN) && at_min));
   assign hld_fault = track_act && !reset_pd;

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      lock_nxt   = lock_cnt;
      run_nxt    = run_cnt;
      retry_nxt  = retry;
      prev_nxt   = prev_dir;
      if (!en) begin
         state_nxt  = ST_IDLE;
         settle_nxt = '0;
         lock_nxt   = '0;
         run_nxt    = '0;
         retry_nxt  = '0;
         prev_nxt   = DIR_NONE;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = ST_START;
            ST_START: begin
               state_nxt  = ST_SETTLE;
               settle_nxt = '0;
            end
            ST_SETTLE: begin
               if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
                  state_nxt  = ST_TRACK;
                  settle_nxt = '0;
                  lock_nxt   = '0;
                  run_nxt    = '0;
                  prev_nxt   = DIR_NONE;
               end else begin
                  settle_nxt = settle_cnt + SETTLE_W'(1);
               end
            end
            ST_TRACK, ST_LOCKED: begin
               prev_nxt = cur_dir;
               // Faults win over any lock/loss decision in the same cycle
               if (hld_fault || sat_fault) begin
                  state_nxt = ST_FAULT;
                  lock_nxt  = '0;
                  run_nxt   = '0;
                  prev_nxt  = DIR_NONE;
               end else if (state == ST_TRACK) begin
                  run_nxt = '0;
                  if (same_dir)
                     lock_nxt = '0;
                  else if (lock_cnt == LOCK_W'(LOCK_CNT - 1)) begin
                     state_nxt = ST_LOCKED;
                     lock_nxt  = '0;
                  end else
                     lock_nxt = lock_cnt + LOCK_W'(1);
               end else begin
                  if (run_inc == RUN_W'(LOSS_RUN)) begin
                     state_nxt = ST_TRACK;
                     lock_nxt  = '0;
                     run_nxt   = '0;
                  end else
                     run_nxt = run_inc;
               end
            end
            ST_FAULT: begin
               retry_nxt  = retry + RETRY_W'(1);
               settle_nxt = '0;
               state_nxt  = (retry + RETRY_W'(1) == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_SETTLE;
            end
            ST_FAIL:  state_nxt = ST_FAIL;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         lock_cnt   <= '0;
         run_cnt    <= '0;
         retry      <= '0;
         prev_dir   <= DIR_NONE;
         pd_en      <= 1'b0;
         hld_rst_n  <= 1'b0;
         locked     <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         lock_cnt   <= lock_nxt;
         run_cnt    <= run_nxt;
         retry      <= retry_nxt;
         prev_dir   <= prev_nxt;
         // Outputs are decoded from the next state so they line up with state_o
         pd_en      <= (state_nxt == ST_TRACK) || (state_nxt == ST_LOCKED);
         hld_rst_n  <= (state_nxt == ST_SETTLE) || (state_nxt == ST_TRACK) ||
                       (state_nxt == ST_LOCKED);
         locked     <= (state_nxt == ST_LOCKED);
         fail       <= (state_nxt == ST_FAIL);
      end
   end

   assign state_o   = state;
   assign code_load = (state_nxt == ST_IDLE) || (state_nxt == ST_START) ||
                      (state_nxt == ST_FAULT);

   fmdll_code_ctr #(
      .CODE_W  (CODE_W),
      .RST_VAL (CODE_INIT)
   ) u_code_ctr (
      .clk_ext  (clk_ext),
      .rst_n    (rst_n),
      .load     (code_load),
      .load_val (CODE_W'(CODE_INIT)),
      .up       (track_act && pd_up),
      .dn       (track_act && pd_dn),
      .code     (code),
      .at_max   (at_max),
      .at_min   (at_min)
   );

`ifdef FMDLL_LOCK_SEQ_DBG_EN
   logic [7:0] relock_cnt;
   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n)
         relock_cnt <= '0;
      else if (!en)
         relock_cnt <= '0;
      else if ((state == ST_LOCKED) && (state_nxt == ST_TRACK) && (relock_cnt != 8'hFF))
         relock_cnt <= relock_cnt + 8'd1;
   end
   assign dbg_relock = relock_cnt;
`endif

endmodule
